// File: rtl/riscv_pkg.sv
// Shared RV32 front-end definitions: reset PC, NOP encoding, fetch FSM states,
// base opcodes and the word-alignment helper used by the fetch path.
package riscv_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [31:0] PC_STEP          = 32'd4;

  typedef enum logic [1:0] {
    FS_FETCH = 2'd0,
    FS_HOLD  = 2'd1,
    FS_DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID output-stage register: load a fetched entry, flush to a NOP bubble,
// or retire the current entry once downstream has taken it.
module if_id_reg
  import riscv_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_flush,
  input  logic         i_consume,
  input  fetch_entry_t i_entry,
  output logic         o_valid,
  output logic [31:0]  o_instr,
  output logic [31:0]  o_pc,
  output logic [31:0]  o_pc_plus4
);

  // Flush beats load: a redirect must never let a wrong-path word through.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid    <= 1'b0;
      o_instr    <= NOP_INSTR;
      o_pc       <= '0;
      o_pc_plus4 <= '0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
      o_instr <= NOP_INSTR;
    end else if (i_load) begin
      o_valid    <= 1'b1;
      o_instr    <= i_entry.instr;
      o_pc       <= i_entry.pc;
      o_pc_plus4 <= i_entry.pc + PC_STEP;
    end else if (i_consume) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding memory request, one-entry skid buffer
// for downstream stalls, and a drain state so redirects never tear a request.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic        valid_out,
  output logic [31:0] instr_out,
  output logic [6:0]  opcode_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4_out
);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_target;
  logic         r_skid_valid;
  fetch_entry_t r_skid;

  logic [31:0]  w_target;
  logic         w_can_load;
  logic         w_load;
  logic         w_flush;
  logic         w_consume;
  fetch_entry_t w_load_entry;
  fetch_entry_t w_rsp_entry;

  assign w_target    = word_align(redirect_target);
  assign w_can_load  = !valid_out || !stall;
  assign w_rsp_entry = '{instr: imem_rdata, pc: r_pc};

  // Request drops in the same cycle rst rises so the memory abandons it at once.
  assign imem_req   = !rst && (r_state != FS_HOLD);
  assign imem_addr  = r_pc;
  assign opcode_out = instr_out[6:0];

  always_comb begin
    w_flush      = redirect;
    w_load       = 1'b0;
    w_consume    = 1'b0;
    w_load_entry = w_rsp_entry;
    if (!redirect) begin
      case (r_state)
        FS_FETCH: begin
          if (imem_valid && w_can_load) w_load = 1'b1;
          else if (valid_out && !stall) w_consume = 1'b1;
        end
        FS_HOLD: begin
          if (!stall && r_skid_valid) begin
            w_load       = 1'b1;
            w_load_entry = r_skid;
          end
        end
        default: begin
          if (valid_out && !stall) w_consume = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= FS_FETCH;
      r_pc         <= word_align(RESET_PC);
      r_target     <= word_align(RESET_PC);
      r_skid_valid <= 1'b0;
      r_skid       <= '0;
    end else begin
      case (r_state)
        FS_FETCH: begin
          if (redirect) begin
            if (imem_valid) begin
              r_pc <= w_target;
            end else begin
              // Old address stays on the bus until memory answers it.
              r_target <= w_target;
              r_state  <= FS_DRAIN;
            end
          end else if (imem_valid) begin
            r_pc <= r_pc + PC_STEP;
            if (!w_can_load) begin
              r_skid       <= w_rsp_entry;
              r_skid_valid <= 1'b1;
              r_state      <= FS_HOLD;
            end
          end
        end
        FS_HOLD: begin
          if (redirect) begin
            r_pc         <= w_target;
            r_skid_valid <= 1'b0;
            r_state      <= FS_FETCH;
          end else if (!stall) begin
            r_skid_valid <= 1'b0;
            r_state      <= FS_FETCH;
          end
        end
        FS_DRAIN: begin
          if (imem_valid) begin
            r_pc    <= redirect ? w_target : r_target;
            r_state <= FS_FETCH;
          end else if (redirect) begin
            r_target <= w_target;
          end
        end
        default: r_state <= FS_FETCH;
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_flush    (w_flush),
    .i_consume  (w_consume),
    .i_entry    (w_load_entry),
    .o_valid    (valid_out),
    .o_instr    (instr_out),
    .o_pc       (pc_out),
    .o_pc_plus4 (pc_plus4_out)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a latency-programmable memory model feeds
// the main instance, a zero-wait memory feeds a second instance near 2^32.
module tb_fetch_unit;

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [31:0] DATA_OFS  = 32'h0000_0100;
  localparam logic [31:0] WRAP_PC   = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst, stall, redirect;
  logic [31:0] redirect_target;
  logic        imem_req, imem_valid;
  logic [31:0] imem_addr, imem_rdata;
  logic        valid_out;
  logic [31:0] instr_out, pc_out, pc_plus4_out;
  logic [6:0]  opcode_out;

  logic        w_imem_req;
  logic [31:0] w_imem_addr;
  logic        w_valid_out;
  logic [31:0] w_instr_out, w_pc_out, w_pc_plus4_out;
  logic [6:0]  w_opcode_out;

  int          latency = 0;
  logic [3:0]  mem_wait = '0;
  int          hs_cnt = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t        sb_q[$];
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] drain_tgt = 32'h0;
  bit          drain_pending = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .valid_out(valid_out),
    .instr_out(instr_out), .opcode_out(opcode_out), .pc_out(pc_out),
    .pc_plus4_out(pc_plus4_out)
  );

  fetch_unit #(.RESET_PC(WRAP_PC)) dut_wrap (
    .clk(clk), .rst(rst), .stall(1'b0), .redirect(1'b0),
    .redirect_target(32'h0), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_valid(w_imem_req), .imem_rdata(w_imem_addr + DATA_OFS), .valid_out(w_valid_out),
    .instr_out(w_instr_out), .opcode_out(w_opcode_out), .pc_out(w_pc_out),
    .pc_plus4_out(w_pc_plus4_out)
  );

  // Memory answers after 'latency' waiting cycles; data is address + 0x100.
  always_comb begin
    imem_valid = imem_req && (int'(mem_wait) >= latency);
    imem_rdata = imem_addr + DATA_OFS;
  end

  always @(posedge clk) begin
    if (!imem_req || imem_valid) mem_wait <= '0;
    else mem_wait <= mem_wait + 4'd1;
    if (imem_req && imem_valid) hs_cnt <= hs_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Evaluate the coming edge with stable inputs, update the model, advance.
  task automatic cycle();
    exp_t e;
    #1;
    if (!rst && valid_out && !stall) begin
      check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        $display("txn pc=%h instr=%h", pc_out, instr_out);
        check("pc_out", pc_out, e.pc);
        check("instr_out", instr_out, e.instr);
        check("pc_plus4_out", pc_plus4_out, e.pc + 32'd4);
        check("opcode_out", 32'(opcode_out), 32'(e.instr[6:0]));
      end
    end
    if (rst) begin
      sb_q.delete();
      exp_pc = 32'h0;
      drain_pending = 1'b0;
    end else if (redirect) begin
      sb_q.delete();
      if (imem_req && !imem_valid) begin
        drain_pending = 1'b1;
        drain_tgt = redirect_target & 32'hFFFF_FFFC;
      end else begin
        drain_pending = 1'b0;
        exp_pc = redirect_target & 32'hFFFF_FFFC;
      end
    end else if (imem_req && imem_valid) begin
      if (drain_pending) begin
        drain_pending = 1'b0;
        exp_pc = drain_tgt;
      end else begin
        check("imem_addr", imem_addr, exp_pc);
        sb_q.push_back('{pc: exp_pc, instr: exp_pc + DATA_OFS});
        exp_pc = exp_pc + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] saved_instr, saved_pc, stale_addr;
    int h0;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
    @(negedge clk);
    repeat (2) cycle();

    // Reset state
    check("rst_req", imem_req, 1'b0);
    check("rst_valid", valid_out, 1'b0);
    check("rst_instr", instr_out, NOP);
    check("rst_pc", pc_out, 32'h0);
    check("rst_pc4", pc_plus4_out, 32'h0);
    check("rst_w_req", w_imem_req, 1'b0);

    // Zero-wait streaming, both instances
    rst = 1'b0; #1;
    check("first_req", imem_req, 1'b1);
    check("first_addr", imem_addr, 32'h0);
    check("first_valid", valid_out, 1'b0);
    check("w_first_addr", w_imem_addr, WRAP_PC);
    cycle();
    check("c2_valid", valid_out, 1'b1);
    check("c2_pc", pc_out, 32'h0);
    check("w_c2_pc", w_pc_out, WRAP_PC);
    cycle();
    check("c3_pc", pc_out, 32'h4);
    check("w_c3_pc", w_pc_out, 32'hFFFF_FFFC);
    check("w_c3_pc4", w_pc_plus4_out, 32'h0);
    cycle();
    check("c4_pc", pc_out, 32'h8);
    check("w_c4_pc", w_pc_out, 32'h0);
    cycle();
    check("c5_pc", pc_out, 32'hC);

    // Stall for three cycles while a response arrives
    stall = 1'b1;
    saved_instr = instr_out; saved_pc = pc_out; h0 = hs_cnt;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("hold_req", imem_req, 1'b0);
      check("hold_instr", instr_out, saved_instr);
      check("hold_pc", pc_out, saved_pc);
    end
    check("skid_captures", 32'(hs_cnt - h0), 32'd1);
    stall = 1'b0;
    repeat (6) cycle();

    // Redirect from HOLD
    stall = 1'b1;
    repeat (2) cycle();
    check("hold2_req", imem_req, 1'b0);
    redirect = 1'b1; redirect_target = 32'h600;
    cycle();
    redirect = 1'b0; stall = 1'b0; #1;
    check("hold_redir_addr", imem_addr, 32'h600);
    check("hold_redir_valid", valid_out, 1'b0);
    cycle();
    check("hold_redir_pc", pc_out, 32'h600);
    repeat (2) cycle();

    // Redirect to 0x80 with a 3-cycle memory latency outstanding
    latency = 3; #1;
    check("lat_pending", imem_valid, 1'b0);
    stale_addr = exp_pc;
    stall = 1'b1; redirect = 1'b1; redirect_target = 32'h80;
    cycle();
    redirect = 1'b0; stall = 1'b0;
    for (int k = 0; k < 10 && !imem_valid; k++) begin
      check("drain_addr", imem_addr, stale_addr);
      check("drain_req", imem_req, 1'b1);
      check("drain_valid_out", valid_out, 1'b0);
      cycle();
    end
    check("drain_rsp_seen", imem_valid, 1'b1);
    check("drain_addr_at_rsp", imem_addr, stale_addr);
    cycle();
    check("post_drain_addr", imem_addr, 32'h80);
    check("post_drain_valid", valid_out, 1'b0);
    for (int k = 0; k < 10 && !valid_out; k++) cycle();
    check("redir80_valid", valid_out, 1'b1);
    check("redir80_pc", pc_out, 32'h80);

    // Two redirects during DRAIN: the later target wins
    for (int k = 0; k < 10 && imem_valid; k++) cycle();
    stall = 1'b1; redirect = 1'b1; redirect_target = 32'h200;
    cycle();
    redirect_target = 32'h300; #1;
    check("drain2_no_rsp", imem_valid, 1'b0);
    cycle();
    redirect = 1'b0; stall = 1'b0;
    for (int k = 0; k < 20 && !valid_out; k++) cycle();
    check("latest_valid", valid_out, 1'b1);
    check("latest_pc", pc_out, 32'h300);

    // Redirect to unaligned 0x43 in the same cycle as a response
    latency = 0;
    repeat (4) cycle();
    stall = 1'b1; redirect = 1'b1; redirect_target = 32'h43; #1;
    check("same_cyc_rsp", imem_valid, 1'b1);
    cycle();
    redirect = 1'b0; stall = 1'b0; #1;
    check("align_addr", imem_addr, 32'h40);
    check("align_valid", valid_out, 1'b0);
    cycle();
    check("align_pc", pc_out, 32'h40);
    check("align_instr", instr_out, 32'h140);
    repeat (3) cycle();

    // Reset raised while draining
    latency = 3;
    for (int k = 0; k < 10 && imem_valid; k++) cycle();
    stall = 1'b1; redirect = 1'b1; redirect_target = 32'h500;
    cycle();
    redirect = 1'b0; stall = 1'b0; #1;
    check("in_drain_req", imem_req, 1'b1);
    rst = 1'b1; #1;
    check("rst_drain_req_now", imem_req, 1'b0);
    cycle();
    check("rst_drain_req", imem_req, 1'b0);
    check("rst_drain_valid", valid_out, 1'b0);
    check("rst_drain_instr", instr_out, NOP);
    rst = 1'b0; latency = 0; #1;
    check("resume_req", imem_req, 1'b1);
    check("resume_addr", imem_addr, 32'h0);
    cycle();
    check("resume_valid", valid_out, 1'b1);
    check("resume_pc", pc_out, 32'h0);
    repeat (4) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
